// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, ALU
// operation codes, opcode/funct values and the decoded instruction class.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        CLS_ADD, CLS_ADDU, CLS_SUB, CLS_SUBU, CLS_AND, CLS_OR, CLS_SLL,
        CLS_SLT, CLS_SLTU, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_BGTZ
    } instr_class_e;

    function automatic logic [2:0] alu_ctr_of(instr_class_e cls);
        logic [2:0] ctr;
        case (cls)
            CLS_AND:  ctr = ALU_AND;
            CLS_OR:   ctr = ALU_OR;
            CLS_SLT:  ctr = ALU_SLT;
            CLS_ADDU: ctr = ALU_ADDU;
            CLS_SLL:  ctr = ALU_SLL;
            CLS_SUB, CLS_SUBU, CLS_BEQ, CLS_BNE, CLS_BGTZ: ctr = ALU_SUB;
            CLS_SLTU: ctr = ALU_SLTU;
            default:  ctr = ALU_ADD;
        endcase
        return ctr;
    endfunction

    function automatic logic is_rtype(instr_class_e cls);
        return cls inside {CLS_ADD, CLS_ADDU, CLS_SUB, CLS_SUBU, CLS_AND,
                           CLS_OR, CLS_SLL, CLS_SLT, CLS_SLTU};
    endfunction

    function automatic logic is_branch(instr_class_e cls);
        return cls inside {CLS_BEQ, CLS_BNE, CLS_BGTZ};
    endfunction

    function automatic logic uses_imm(instr_class_e cls);
        return cls inside {CLS_ADDI, CLS_LW, CLS_SW};
    endfunction

    function automatic logic is_mem(instr_class_e cls);
        return cls inside {CLS_LW, CLS_SW};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_ctrl_if;

    logic [5:0]  op;
    logic [5:0]  fun;
    logic        equal;
    logic        sign;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_wr;
    logic        i_or_d;
    logic        ir_wr;
    logic        pc_wr;
    logic        npc_sel;
    logic        reg_wr;
    logic        reg_dst;
    logic        alu_src;
    logic        ext_op;
    logic        mem_to_reg;
    logic [2:0]  alu_ctr;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic        mem_err;
    logic [31:0] retired;

    modport master (
        input  op, fun, equal, sign, mem_ready,
        output mem_req, mem_wr, i_or_d, ir_wr, pc_wr, npc_sel, reg_wr,
               reg_dst, alu_src, ext_op, mem_to_reg, alu_ctr, state,
               halted, illegal, mem_err, retired
    );

    modport slave (
        output op, fun, equal, sign, mem_ready,
        input  mem_req, mem_wr, i_or_d, ir_wr, pc_wr, npc_sel, reg_wr,
               reg_dst, alu_src, ext_op, mem_to_reg, alu_ctr, state,
               halted, illegal, mem_err, retired
    );

endinterface

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct decoder: maps an instruction to its class and
// flags anything outside the supported subset as not legal.
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]   op_i,
    input  logic [5:0]   fun_i,
    output instr_class_e cls_o,
    output logic         legal_o
);

    always_comb begin
        cls_o   = CLS_ADD;
        legal_o = 1'b1;
        case (op_i)
            OP_RTYPE: begin
                case (fun_i)
                    FN_ADD:  cls_o = CLS_ADD;
                    FN_ADDU: cls_o = CLS_ADDU;
                    FN_SUB:  cls_o = CLS_SUB;
                    FN_SUBU: cls_o = CLS_SUBU;
                    FN_AND:  cls_o = CLS_AND;
                    FN_OR:   cls_o = CLS_OR;
                    FN_SLL:  cls_o = CLS_SLL;
                    FN_SLT:  cls_o = CLS_SLT;
                    FN_SLTU: cls_o = CLS_SLTU;
                    default: legal_o = 1'b0;
                endcase
            end
            OP_ADDI: cls_o = CLS_ADDI;
            OP_LW:   cls_o = CLS_LW;
            OP_SW:   cls_o = CLS_SW;
            OP_BEQ:  cls_o = CLS_BEQ;
            OP_BNE:  cls_o = CLS_BNE;
            OP_BGTZ: cls_o = CLS_BGTZ;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with memory
// wait timeout. Define PERF_CNT_EN to build the retired-instruction counter.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e       state_q;
    instr_class_e cls_q;
    logic [7:0]   wait_q;
    logic         halted_q;
    logic         illegal_q;
    logic         mem_err_q;

    instr_class_e dec_cls;
    logic         dec_legal;
    logic         taken;
    logic         wait_expired;

    logic         mem_req, mem_wr, i_or_d, ir_wr, pc_wr, npc_sel;
    logic         reg_wr, reg_dst, alu_src, ext_op, mem_to_reg;
    logic [2:0]   alu_ctr;

    instr_class_decode u_decode (
        .op_i    (bus.op),
        .fun_i   (bus.fun),
        .cls_o   (dec_cls),
        .legal_o (dec_legal)
    );

    assign taken = ((cls_q == CLS_BEQ)  &&  bus.equal) ||
                   ((cls_q == CLS_BNE)  && !bus.equal) ||
                   ((cls_q == CLS_BGTZ) && !bus.equal && !bus.sign);

    // A ready arriving on the last allowed wait cycle still wins over the timeout.
    assign wait_expired = (wait_q == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_ADD;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        state_q <= ST_DECODE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                        if (wait_expired) begin
                            state_q   <= ST_HALT;
                            halted_q  <= 1'b1;
                            mem_err_q <= 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    if (dec_legal) begin
                        cls_q   <= dec_cls;
                        state_q <= ST_EXEC;
                    end else begin
                        state_q   <= ST_HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    wait_q <= '0;
                    if (is_mem(cls_q)) begin
                        state_q <= ST_MEM;
                    end else if (is_branch(cls_q)) begin
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        wait_q <= '0;
                        if (cls_q == CLS_SW) begin
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                        if (wait_expired) begin
                            state_q   <= ST_HALT;
                            halted_q  <= 1'b1;
                            mem_err_q <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    wait_q  <= '0;
                    state_q <= ST_FETCH;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are decoded from the current state; reset forces them all low.
    always_comb begin
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        i_or_d     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        npc_sel    = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        mem_to_reg = 1'b0;
        alu_ctr    = 3'd0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_wr = 1'b1;
                        pc_wr = 1'b1;
                    end
                end
                ST_EXEC: begin
                    alu_ctr = alu_ctr_of(cls_q);
                    alu_src = uses_imm(cls_q);
                    ext_op  = uses_imm(cls_q);
                    reg_dst = is_rtype(cls_q);
                    if (taken) begin
                        npc_sel = 1'b1;
                        pc_wr   = 1'b1;
                    end
                end
                ST_MEM: begin
                    alu_ctr = alu_ctr_of(cls_q);
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                    mem_wr  = (cls_q == CLS_SW);
                end
                ST_WB: begin
                    alu_ctr    = alu_ctr_of(cls_q);
                    reg_wr     = 1'b1;
                    mem_to_reg = (cls_q == CLS_LW);
                    reg_dst    = is_rtype(cls_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_wr     = mem_wr;
    assign bus.i_or_d     = i_or_d;
    assign bus.ir_wr      = ir_wr;
    assign bus.pc_wr      = pc_wr;
    assign bus.npc_sel    = npc_sel;
    assign bus.reg_wr     = reg_wr;
    assign bus.reg_dst    = reg_dst;
    assign bus.alu_src    = alu_src;
    assign bus.ext_op     = ext_op;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_ctr    = alu_ctr;
    assign bus.state      = state_q;
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;
    assign bus.mem_err    = mem_err_q;

`ifdef PERF_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    assign retire = (state_q == ST_WB) ||
                    ((state_q == ST_MEM) && (cls_q == CLS_SW) && bus.mem_ready) ||
                    ((state_q == ST_EXEC) && is_branch(cls_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4); the
// retired-count expectation follows the PERF_CNT_EN build option.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

`ifdef PERF_CNT_EN
    localparam logic [31:0] RETIRE_EXP = 32'd10;
`else
    localparam logic [31:0] RETIRE_EXP = 32'd0;
`endif

    logic clk;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {mem_req, mem_wr, i_or_d, ir_wr, pc_wr, npc_sel, reg_wr, reg_dst, alu_src, ext_op, mem_to_reg}
    logic [10:0] strobes;
    assign strobes = {bus.mem_req, bus.mem_wr, bus.i_or_d, bus.ir_wr, bus.pc_wr, bus.npc_sel,
                      bus.reg_wr, bus.reg_dst, bus.alu_src, bus.ext_op, bus.mem_to_reg};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic doReset();
        rst = 1'b1;
        bus.op = 6'h00; bus.fun = 6'h00; bus.equal = 1'b0; bus.sign = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.op = OP_RTYPE; bus.fun = FN_ADD; bus.equal = 1'b1; bus.sign = 1'b0; bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checkCount++;
            if (bus.state !== ST_FETCH || strobes !== 11'h000 || bus.alu_ctr !== 3'd0 ||
                {bus.halted, bus.illegal, bus.mem_err} !== 3'b000 || bus.retired !== 32'd0) begin
                errorCount++;
                $display("[TB] FAIL reset_hold %0d: state=%0d strobes=%h flags=%b retired=%0d, expected 0/000/000/0",
                         i, bus.state, strobes, {bus.halted, bus.illegal, bus.mem_err}, bus.retired);
            end
        end
        rst = 1'b0;
        #1;
        checkCount++;
        if (bus.state !== ST_FETCH || strobes !== 11'h4C0) begin
            errorCount++;
            $display("[TB] FAIL reset_release: state=%0d strobes=%h, expected 0/4c0", bus.state, strobes);
        end
    endtask

    task automatic test_add();
        logic [2:0]  expSt  [5] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH};
        logic [10:0] expStb [5] = '{11'h4C0, 11'h000, 11'h008, 11'h018, 11'h4C0};
        logic [2:0]  expAlu [5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0};
        doReset();
        bus.op = OP_RTYPE; bus.fun = FN_ADD;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(posedge clk);
            #1 bus.mem_ready = 1'b1;
            #1;
            checkCount++;
            if (bus.state !== expSt[i] || strobes !== expStb[i] || bus.alu_ctr !== expAlu[i]) begin
                errorCount++;
                $display("[TB] FAIL add cycle %0d: state=%0d strobes=%h alu=%0d, expected %0d/%h/%0d",
                         i + 1, bus.state, strobes, bus.alu_ctr, expSt[i], expStb[i], expAlu[i]);
            end
        end
    endtask

    task automatic test_lw();
        logic [2:0]  expSt  [9] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM, ST_MEM, ST_MEM, ST_WB, ST_FETCH};
        logic        rdy    [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [10:0] expStb [9] = '{11'h4C0, 11'h000, 11'h006, 11'h500, 11'h500, 11'h500, 11'h500, 11'h011, 11'h400};
        logic [2:0]  expAlu [9] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
        doReset();
        bus.op = OP_LW; bus.fun = 6'h15;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(posedge clk);
            #1 bus.mem_ready = rdy[i];
            #1;
            checkCount++;
            if (bus.state !== expSt[i] || strobes !== expStb[i] || bus.alu_ctr !== expAlu[i]) begin
                errorCount++;
                $display("[TB] FAIL lw cycle %0d: state=%0d strobes=%h alu=%0d, expected %0d/%h/%0d",
                         i + 1, bus.state, strobes, bus.alu_ctr, expSt[i], expStb[i], expAlu[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [2:0]  expSt  [5] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_FETCH};
        logic        rdy    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [10:0] expStb [5] = '{11'h4C0, 11'h000, 11'h006, 11'h700, 11'h400};
        logic [2:0]  expAlu [5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0};
        doReset();
        bus.op = OP_SW;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(posedge clk);
            #1 bus.mem_ready = rdy[i];
            #1;
            checkCount++;
            if (bus.state !== expSt[i] || strobes !== expStb[i] || bus.alu_ctr !== expAlu[i]) begin
                errorCount++;
                $display("[TB] FAIL sw cycle %0d: state=%0d strobes=%h alu=%0d, expected %0d/%h/%0d",
                         i + 1, bus.state, strobes, bus.alu_ctr, expSt[i], expStb[i], expAlu[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  brOp    [5] = '{OP_BGTZ, OP_BGTZ, OP_BGTZ, OP_BEQ, OP_BNE};
        logic        brEq    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        brSign  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        brTaken [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  expSt   [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH};
        logic        rdy     [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [10:0] baseStb [4] = '{11'h4C0, 11'h000, 11'h000, 11'h400};
        logic [2:0]  expAlu  [4] = '{3'd0, 3'd0, 3'd6, 3'd0};
        logic [10:0] expS;
        for (int c = 0; c < 5; c++) begin
            doReset();
            bus.op = brOp[c]; bus.equal = brEq[c]; bus.sign = brSign[c];
            for (int i = 0; i < 4; i++) begin
                if (i != 0) @(posedge clk);
                #1 bus.mem_ready = rdy[i];
                #1;
                expS = baseStb[i];
                if (i == 2 && brTaken[c]) expS = 11'h060;
                checkCount++;
                if (bus.state !== expSt[i] || strobes !== expS || bus.alu_ctr !== expAlu[i]) begin
                    errorCount++;
                    $display("[TB] FAIL branch case %0d cycle %0d: state=%0d strobes=%h alu=%0d, expected %0d/%h/%0d",
                             c, i + 1, bus.state, strobes, bus.alu_ctr, expSt[i], expS, expAlu[i]);
                end
            end
        end
    endtask

    task automatic test_alu_map();
        logic [5:0]  mOp  [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                   6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07};
        logic [5:0]  mFun [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h2A, 6'h2B,
                                   6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        logic [2:0]  mAlu [15] = '{3'd2, 3'd4, 3'd6, 3'd6, 3'd0, 3'd1, 3'd5, 3'd3, 3'd7,
                                   3'd2, 3'd2, 3'd2, 3'd6, 3'd6, 3'd6};
        logic [10:0] mStb [15] = '{11'h008, 11'h008, 11'h008, 11'h008, 11'h008, 11'h008, 11'h008, 11'h008, 11'h008,
                                   11'h006, 11'h006, 11'h006, 11'h000, 11'h060, 11'h000};
        for (int k = 0; k < 15; k++) begin
            doReset();
            bus.op = mOp[k]; bus.fun = mFun[k]; bus.equal = 1'b0; bus.sign = 1'b1; bus.mem_ready = 1'b1;
            repeat (2) @(posedge clk);
            #2;
            checkCount++;
            if (bus.state !== ST_EXEC || bus.alu_ctr !== mAlu[k] || strobes !== mStb[k]) begin
                errorCount++;
                $display("[TB] FAIL alu_map op=%h fun=%h: state=%0d alu=%0d strobes=%h, expected %0d/%0d/%h",
                         mOp[k], mFun[k], bus.state, bus.alu_ctr, strobes, ST_EXEC, mAlu[k], mStb[k]);
            end
        end
    endtask

    task automatic test_illegal();
        doReset();
        bus.op = 6'h3F; bus.mem_ready = 1'b1;
        @(posedge clk); #2;
        checkCount++;
        if (bus.state !== ST_DECODE || bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL illegal_decode: state=%0d halted=%b illegal=%b, expected 1/0/0",
                     bus.state, bus.halted, bus.illegal);
        end
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1 bus.op = 6'(i * 7); bus.equal = i[0]; bus.sign = i[1]; bus.mem_ready = ~i[2];
            #1;
            checkCount++;
            if (bus.state !== ST_HALT || strobes !== 11'h000 || bus.alu_ctr !== 3'd0 ||
                {bus.halted, bus.illegal, bus.mem_err} !== 3'b110) begin
                errorCount++;
                $display("[TB] FAIL illegal_halt cycle %0d: state=%0d strobes=%h alu=%0d flags=%b, expected 5/000/0/110",
                         i, bus.state, strobes, bus.alu_ctr, {bus.halted, bus.illegal, bus.mem_err});
            end
        end
        rst = 1'b1;
        #1;
        checkCount++;
        if (bus.state !== ST_FETCH || {bus.halted, bus.illegal, bus.mem_err} !== 3'b000 || strobes !== 11'h000) begin
            errorCount++;
            $display("[TB] FAIL illegal_rst_clear: state=%0d flags=%b strobes=%h, expected 0/000/000",
                     bus.state, {bus.halted, bus.illegal, bus.mem_err}, strobes);
        end
        doReset();
        bus.op = OP_RTYPE; bus.fun = 6'h3F; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkCount++;
        if (bus.state !== ST_HALT || {bus.halted, bus.illegal, bus.mem_err} !== 3'b110) begin
            errorCount++;
            $display("[TB] FAIL illegal_funct: state=%0d flags=%b, expected 5/110",
                     bus.state, {bus.halted, bus.illegal, bus.mem_err});
        end
    endtask

    task automatic test_timeout();
        logic [5:0] toOp   [4] = '{OP_RTYPE, OP_RTYPE, OP_SW, OP_SW};
        logic [7:0] toRdy  [4] = '{8'b0000_0000, 8'b0000_1000, 8'b0000_0111, 8'b0100_0111};
        int         toLen  [4] = '{5, 5, 8, 8};
        logic [2:0] penSt  [4] = '{ST_FETCH, ST_FETCH, ST_MEM, ST_MEM};
        logic [2:0] finSt  [4] = '{ST_HALT, ST_DECODE, ST_HALT, ST_FETCH};
        logic [2:0] finFlg [4] = '{3'b101, 3'b000, 3'b101, 3'b000};
        logic [10:0] finStb [4] = '{11'h000, 11'h000, 11'h000, 11'h400};
        for (int s = 0; s < 4; s++) begin
            doReset();
            bus.op = toOp[s]; bus.fun = FN_ADD;
            for (int i = 0; i < toLen[s]; i++) begin
                if (i != 0) @(posedge clk);
                #1 bus.mem_ready = toRdy[s][i];
                #1;
                if (i == toLen[s] - 2) begin
                    checkCount++;
                    if (bus.state !== penSt[s]) begin
                        errorCount++;
                        $display("[TB] FAIL timeout_wait scen %0d: state=%0d, expected %0d",
                                 s, bus.state, penSt[s]);
                    end
                end
            end
            checkCount++;
            if (bus.state !== finSt[s] || {bus.halted, bus.illegal, bus.mem_err} !== finFlg[s] ||
                strobes !== finStb[s]) begin
                errorCount++;
                $display("[TB] FAIL timeout_end scen %0d: state=%0d flags=%b strobes=%h, expected %0d/%b/%h",
                         s, bus.state, {bus.halted, bus.illegal, bus.mem_err}, strobes,
                         finSt[s], finFlg[s], finStb[s]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] bbOp  [10] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h00, 6'h00, 6'h00, 6'h00};
        logic [5:0] bbFun [10] = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h2A, 6'h2B};
        logic       bbEq  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int         bbLat [10] = '{4, 4, 5, 4, 3, 3, 4, 4, 4, 4};
        logic [2:0] bbAlu [10] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd6, 3'd6, 3'd5, 3'd6, 3'd3, 3'd7};
        doReset();
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(posedge clk);
            #1 bus.op = bbOp[k]; bus.fun = bbFun[k]; bus.equal = bbEq[k]; bus.mem_ready = 1'b1;
            #1;
            checkCount++;
            if (bus.state !== ST_FETCH) begin
                errorCount++;
                $display("[TB] FAIL b2b_fetch instr %0d: state=%0d, expected %0d", k, bus.state, ST_FETCH);
            end
            repeat (2) @(posedge clk);
            #2;
            checkCount++;
            if (bus.state !== ST_EXEC || bus.alu_ctr !== bbAlu[k]) begin
                errorCount++;
                $display("[TB] FAIL b2b_exec instr %0d: state=%0d alu=%0d, expected %0d/%0d",
                         k, bus.state, bus.alu_ctr, ST_EXEC, bbAlu[k]);
            end
            repeat (bbLat[k] - 3) @(posedge clk);
        end
        @(posedge clk);
        #2;
        checkCount++;
        if (bus.state !== ST_FETCH || bus.retired !== RETIRE_EXP) begin
            errorCount++;
            $display("[TB] FAIL b2b_retired: state=%0d retired=%0d, expected %0d/%0d",
                     bus.state, bus.retired, ST_FETCH, RETIRE_EXP);
        end
        bus.op = OP_RTYPE; bus.fun = FN_ADD; bus.equal = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkCount++;
        if (bus.state !== ST_WB || bus.reg_wr !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL b2b_wb11: state=%0d reg_wr=%b, expected %0d/1", bus.state, bus.reg_wr, ST_WB);
        end
        rst = 1'b1;
        #1;
        checkCount++;
        if (bus.reg_wr !== 1'b0 || bus.state !== ST_FETCH || bus.retired !== 32'd0 || strobes !== 11'h000) begin
            errorCount++;
            $display("[TB] FAIL b2b_abort: reg_wr=%b state=%0d retired=%0d strobes=%h, expected 0/0/0/000",
                     bus.reg_wr, bus.state, bus.retired, strobes);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkCount++;
        if (bus.state !== ST_FETCH || strobes !== 11'h4C0 || bus.retired !== 32'd0) begin
            errorCount++;
            $display("[TB] FAIL b2b_resume: state=%0d strobes=%h retired=%0d, expected 0/4c0/0",
                     bus.state, strobes, bus.retired);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_branch();
        test_alu_map();
        test_illegal();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
